// File: rtl/add_sched.sv
// Round-robin scheduler that time-shares a single W-bit adder among NREQ requesters.
// Each operation runs IDLE (grant) -> EXEC (add) -> RESP (hold until consumed).
module add_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IDW = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic [1:0]        rsp_status,
    output logic [15:0]       done_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [W-1:0]     a_q, a_d, b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [1:0]       status_q, status_d;
    logic [15:0]      done_q, done_d;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   idx;
    logic [W-1:0]     sum_c;
    logic [W-1:0]     a_arr [NREQ];
    logic [W-1:0]     b_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_lane
        assign a_arr[i] = req_a[i*W +: W];
        assign b_arr[i] = req_b[i*W +: W];
    end

    // Search starts one past the last grant so a waiting requester is never skipped twice.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IDW'((int'(last_q) + k) % NREQ);
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        status_d  = status_q;
        done_d    = done_q;
        req_ready = '0;
        sum_c     = a_q + b_q;
        case (state_q)
            S_IDLE: begin
                if (found && rst_n) begin
                    req_ready[win] = 1'b1;
                    state_d        = S_EXEC;
                    last_d         = win;
                    id_d           = win;
                    a_d            = a_arr[win];
                    b_d            = b_arr[win];
                end
            end
            S_EXEC: begin
                sum_d    = sum_c;
                status_d = (sum_c == '0) ? 2'b00 : (sum_c == '1) ? 2'b01 : 2'b10;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                    done_d  = done_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            last_q   <= IDW'(NREQ - 1);
            id_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            status_q <= 2'b00;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    // Response fields read as zero whenever no response is being offered.
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_id     = rsp_valid ? id_q : '0;
    assign rsp_sum    = rsp_valid ? sum_q : '0;
    assign rsp_status = rsp_valid ? status_q : 2'b00;
    assign done_cnt   = done_q;

endmodule

// File: tb/tb_add_sched.sv
// Randomized bench for add_sched: a round-robin/adder reference model predicts every
// grant, result and completion count.
module tb_add_sched;
    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid, req_ready;
    logic [NREQ*W-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic [1:0]        rsp_status;
    logic [15:0]       done_cnt;

    int nvec = 0, nerr = 0;
    int last_g = NREQ - 1;
    int done_m = 0;

    add_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_status(rsp_status), .done_cnt(done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Reference: winner is the first valid requester after the previous winner, wrapping.
    task automatic model_op(output int w, output logic [W-1:0] s, output logic [1:0] st);
        logic [NREQ-1:0] t;
        logic [W-1:0]    ea, eb;
        w = -1;
        for (int j = 1; j <= NREQ && w < 0; j++) begin
            t = req_valid >> ((last_g + j) % NREQ);
            if (t[0]) w = (last_g + j) % NREQ;
        end
        ea = W'(req_a >> (w * W));
        eb = W'(req_b >> (w * W));
        s  = W'((int'(ea) + int'(eb)) % 256);
        st = (s == 0) ? 2'b00 : (s == 8'hFF) ? 2'b01 : 2'b10;
        last_g = w;
        done_m = (done_m + 1) % 65536;
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_ops;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'($urandom);
            req_b[i*W +: W] = W'($urandom);
        end
    endtask

    // Drives one full operation from IDLE; scrambles operands right after the grant.
    task automatic one_op(output logic [NREQ-1:0] rdy, output logic ok, output logic [IDW-1:0] id,
                          output logic [W-1:0] sum, output logic [1:0] st);
        #1 rdy = req_ready;
        tick;
        ok = !rsp_valid;
        rand_ops();
        tick;
        ok = ok && rsp_valid;
        id = rsp_id; sum = rsp_sum; st = rsp_status;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = '1; rand_ops(); rsp_ready = 1'b1;
        tick;
        #1;
        nvec++; if (req_ready !== '0) begin nerr++; $display("FAIL reset.ready got %b want 0", req_ready); end
        nvec++; if ({rsp_valid, rsp_id, rsp_sum, rsp_status} !== '0) begin nerr++; $display("FAIL reset.rsp got %b/%0d/%h/%b want zeros", rsp_valid, rsp_id, rsp_sum, rsp_status); end
        nvec++; if (done_cnt !== 16'd0) begin nerr++; $display("FAIL reset.done got %0d want 0", done_cnt); end
        @(negedge clk);
        req_valid = '0; rsp_ready = 1'b0; rst_n = 1'b1;
        last_g = NREQ - 1; done_m = 0;
        tick;
    endtask

    task automatic test_single;
        logic [NREQ-1:0] rdy; logic ok; logic [IDW-1:0] id; logic [W-1:0] s; logic [1:0] st;
        req_valid = 4'b0100; req_a = '0; req_b = '0;
        req_a[2*W +: W] = 8'd3; req_b[2*W +: W] = 8'd4;
        one_op(rdy, ok, id, s, st);
        req_valid = '0; last_g = 2; done_m = 1;
        nvec++; if (rdy !== 4'b0100) begin nerr++; $display("FAIL single.ready got %b want 0100", rdy); end
        nvec++; if (!ok) begin nerr++; $display("FAIL single.latency got bad want rsp_valid after EXEC"); end
        nvec++; if ({id, s, st} !== {2'd2, 8'd7, 2'b10}) begin nerr++; $display("FAIL single.rsp got %0d/%h/%b want 2/07/10", id, s, st); end
        nvec++; if (done_cnt !== 16'd1) begin nerr++; $display("FAIL single.done got %0d want 1", done_cnt); end
    endtask

    task automatic test_boundaries;
        logic [W-1:0] ba [3] = '{8'hFF, 8'hF0, 8'h00};
        logic [W-1:0] bb [3] = '{8'h01, 8'h0F, 8'h00};
        logic [1:0]   bs [3] = '{2'b00, 2'b01, 2'b00};
        logic [NREQ-1:0] rdy; logic ok; logic [IDW-1:0] id; logic [W-1:0] s; logic [1:0] st;
        int w; logic [W-1:0] es; logic [1:0] est;
        for (int k = 0; k < 3; k++) begin
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            req_a = {NREQ{ba[k]}}; req_b = {NREQ{bb[k]}};
            model_op(w, es, est);
            one_op(rdy, ok, id, s, st);
            req_valid = '0;
            nvec++; if (rdy !== NREQ'(1 << w)) begin nerr++; $display("FAIL bound.ready got %b want %b", rdy, NREQ'(1 << w)); end
            nvec++; if ({s, st} !== {ba[k] + bb[k], bs[k]} || es !== ba[k] + bb[k]) begin nerr++; $display("FAIL bound.sum got %h/%b want %h/%b", s, st, ba[k] + bb[k], bs[k]); end
            nvec++; if (id !== IDW'(w) || !ok) begin nerr++; $display("FAIL bound.id got %0d want %0d", id, w); end
        end
    endtask

    task automatic test_round_robin;
        logic [NREQ-1:0] rdy; logic ok; logic [IDW-1:0] id; logic [W-1:0] s; logic [1:0] st;
        int w; logic [W-1:0] es; logic [1:0] est;
        int first;
        req_valid = '1; rand_ops();
        first = (last_g + 1) % NREQ;
        for (int k = 0; k < 8; k++) begin
            model_op(w, es, est);
            one_op(rdy, ok, id, s, st);
            nvec++; if (rdy !== NREQ'(1 << ((first + k) % NREQ))) begin nerr++; $display("FAIL rr.grant%0d got %b want %b", k, rdy, NREQ'(1 << ((first + k) % NREQ))); end
            nvec++; if (id !== IDW'(w) || s !== es || st !== est || !ok) begin nerr++; $display("FAIL rr.rsp%0d got %0d/%h/%b want %0d/%h/%b", k, id, s, st, w, es, est); end
        end
        req_valid = '0;
        nvec++; if (done_cnt !== 16'(done_m)) begin nerr++; $display("FAIL rr.done got %0d want %0d", done_cnt, done_m); end
    endtask

    task automatic test_backpressure;
        int w; logic [W-1:0] es; logic [1:0] est;
        req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1)); rand_ops();
        model_op(w, es, est);
        #1;
        nvec++; if (req_ready !== NREQ'(1 << w)) begin nerr++; $display("FAIL bp.grant got %b want %b", req_ready, NREQ'(1 << w)); end
        tick; rand_ops(); req_valid = '1; tick;
        for (int c = 0; c < 5; c++) begin
            tick;
            nvec++; if ({rsp_valid, rsp_id, rsp_sum, rsp_status} !== {1'b1, IDW'(w), es, est} || req_ready !== '0 || done_cnt !== 16'(done_m - 1)) begin
                nerr++; $display("FAIL bp.hold%0d got %b/%0d/%h/%b rdy=%b want 1/%0d/%h/%b rdy=0", c, rsp_valid, rsp_id, rsp_sum, rsp_status, req_ready, w, es, est);
            end
        end
        req_valid = '0; rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        nvec++; if ({rsp_valid, rsp_sum} !== '0 || done_cnt !== 16'(done_m)) begin nerr++; $display("FAIL bp.release got v=%b sum=%h done=%0d want 0/00/%0d", rsp_valid, rsp_sum, done_cnt, done_m); end
    endtask

    task automatic test_reset_mid;
        logic [NREQ-1:0] rdy; logic ok; logic [IDW-1:0] id; logic [W-1:0] s; logic [1:0] st;
        int w; logic [W-1:0] es; logic [1:0] est;
        req_valid = 4'b1010; rand_ops();
        tick;
        rst_n = 1'b0;
        #1;
        nvec++; if ({rsp_valid, rsp_id, rsp_sum, rsp_status, req_ready} !== '0 || done_cnt !== 16'd0) begin
            nerr++; $display("FAIL rstmid.async got v=%b sum=%h rdy=%b done=%0d want zeros", rsp_valid, rsp_sum, req_ready, done_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1; req_valid = '0; last_g = NREQ - 1; done_m = 0;
        for (int c = 0; c < 4; c++) begin
            tick;
            nvec++; if (rsp_valid !== 1'b0) begin nerr++; $display("FAIL rstmid.norsp%0d got %b want 0", c, rsp_valid); end
        end
        req_valid = 4'b0110; rand_ops();
        model_op(w, es, est);
        one_op(rdy, ok, id, s, st);
        req_valid = '0;
        nvec++; if (rdy !== 4'b0010 || w != 1) begin nerr++; $display("FAIL rstmid.grant got %b want 0010", rdy); end
        nvec++; if (id !== 2'd1 || s !== es || st !== est || !ok) begin nerr++; $display("FAIL rstmid.rsp got %0d/%h/%b want 1/%h/%b", id, s, st, es, est); end
    endtask

    task automatic test_random;
        logic [NREQ-1:0] rdy; logic ok; logic [IDW-1:0] id; logic [W-1:0] s; logic [1:0] st;
        int w; logic [W-1:0] es; logic [1:0] est;
        for (int k = 0; k < 40; k++) begin
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1)); rand_ops();
            model_op(w, es, est);
            one_op(rdy, ok, id, s, st);
            if ($urandom_range(0, 1) == 1) begin req_valid = '0; tick; end
            nvec++; if (rdy !== NREQ'(1 << w) || !ok) begin nerr++; $display("FAIL rand.grant%0d got %b want %b", k, rdy, NREQ'(1 << w)); end
            nvec++; if (id !== IDW'(w) || s !== es || st !== est) begin nerr++; $display("FAIL rand.rsp%0d got %0d/%h/%b want %0d/%h/%b", k, id, s, st, w, es, est); end
            nvec++; if (done_cnt !== 16'(done_m)) begin nerr++; $display("FAIL rand.done%0d got %0d want %0d", k, done_cnt, done_m); end
        end
        req_valid = '0;
    endtask

    task automatic test_wrap;
        logic [NREQ-1:0] rdy; logic ok; logic [IDW-1:0] id; logic [W-1:0] s; logic [1:0] st;
        int w; logic [W-1:0] es; logic [1:0] est;
        req_valid = '0;
        force dut.done_q = 16'hFFFF;
        tick;
        release dut.done_q;
        tick;
        nvec++; if (done_cnt !== 16'hFFFF) begin nerr++; $display("FAIL wrap.preload got %h want ffff", done_cnt); end
        done_m = 65535;
        for (int k = 0; k < 2; k++) begin
            req_valid = NREQ'($urandom_range(1, (1 << NREQ) - 1)); rand_ops();
            model_op(w, es, est);
            one_op(rdy, ok, id, s, st);
            req_valid = '0;
            nvec++; if (done_cnt !== 16'(k)) begin nerr++; $display("FAIL wrap.cnt%0d got %h want %h", k, done_cnt, 16'(k)); end
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_boundaries();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
